// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit limits, per-nibble validity and a
// most-significant-digit-first magnitude compare on packed BCD words.
package bcd_pkg;

    localparam int         BCD_W      = 4;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam int         MAX_DIGITS = 6;
    localparam int         MAX_W      = BCD_W * MAX_DIGITS;

    // What the counter register does on the next clock edge.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_CLEAR,
        ACT_LOAD,
        ACT_LOAD_BAD,
        ACT_INC,
        ACT_WRAP,
        ACT_SAT
    } act_e;

    // True when the nibble is a legal BCD digit (0..9).
    function automatic logic bcd_valid(input logic [3:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

    // a <= b on packed BCD, walking from the most significant digit down.
    // Only the lowest 'digits' nibbles take part; callers zero-extend
    // narrower words to MAX_W.
    function automatic logic bcd_le(input logic [MAX_W-1:0] a,
                                    input logic [MAX_W-1:0] b,
                                    input int               digits);
        logic decided;
        logic le;
        decided = 1'b0;
        le      = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < digits && !decided) begin
                if (a[i*BCD_W +: BCD_W] < b[i*BCD_W +: BCD_W]) begin
                    le      = 1'b1;
                    decided = 1'b1;
                end else if (a[i*BCD_W +: BCD_W] > b[i*BCD_W +: BCD_W]) begin
                    le      = 1'b0;
                    decided = 1'b1;
                end
            end
        end
        return le;
    endfunction

endpackage

// File: rtl/bcd_digit_inc.sv
// One BCD digit of the increment chain: adds the incoming carry and
// rolls 9 over to 0, passing a carry to the next digit up.
module bcd_digit_inc
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       ci,
    output logic [3:0] digit_next,
    output logic       co
);

    logic at_max;

    assign at_max = (digit == BCD_MAX);
    assign co     = ci & at_max;

    // Increment when carried into, wrapping 9 back to 0.
    always_comb begin
        digit_next = digit;
        if (ci) begin
            digit_next = at_max ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_upcounter.sv
// Multi-digit BCD up-counter with carry in/out for cascading, synchronous
// clear and preset, and a programmable terminal value that either wraps
// to zero or saturates. Sticky flags record terminal-count events and
// rejected presets.
module bcd_upcounter
    import bcd_pkg::*;
#(
    parameter int                  DIGITS = 2,
    parameter logic [4*DIGITS-1:0] LIMIT  = (4*DIGITS)'(8'h59),
    parameter bit                  WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                preset,
    input  logic [4*DIGITS-1:0] BCD_i,
    input  logic                cin,
    output logic [4*DIGITS-1:0] BCD_o,
    output logic                cout,
    output logic                ovf,
    output logic                perr
);

    localparam int W = BCD_W * DIGITS;

    logic [W-1:0]      count_reg;
    logic [W-1:0]      count_next;
    logic              ovf_reg;
    logic              ovf_next;
    logic              perr_reg;
    logic              perr_next;

    logic [W-1:0]      inc_value;
    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] digit_ok;
    logic              at_limit;
    logic              preset_ok;
    act_e              act;

    // The increment chain always adds one; whether it is used is decided
    // by the action select below.
    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_inc u_inc (
                .digit      (count_reg[gi*BCD_W +: BCD_W]),
                .ci         (carry[gi]),
                .digit_next (inc_value[gi*BCD_W +: BCD_W]),
                .co         (carry[gi+1])
            );
            assign digit_ok[gi] = bcd_valid(BCD_i[gi*BCD_W +: BCD_W]);
        end
    endgenerate

    assign at_limit  = (count_reg == LIMIT);
    assign preset_ok = (&digit_ok) &&
                       bcd_le(MAX_W'(BCD_i), MAX_W'(LIMIT), DIGITS);

    // Carry to the next stage only when this stage actually counts through
    // its terminal value; a clear or load in the same cycle suppresses it.
    assign cout = cin & at_limit & ~clr & ~preset;

    // Pick the register action: clr beats preset beats cin beats hold.
    always_comb begin
        act = ACT_HOLD;
        if (clr) begin
            act = ACT_CLEAR;
        end else if (preset) begin
            act = preset_ok ? ACT_LOAD : ACT_LOAD_BAD;
        end else if (cin) begin
            if (at_limit) begin
                act = WRAP ? ACT_WRAP : ACT_SAT;
            end else begin
                act = ACT_INC;
            end
        end
    end

    // Next count and sticky flags for the chosen action.
    always_comb begin
        count_next = count_reg;
        ovf_next   = ovf_reg;
        perr_next  = perr_reg;
        unique case (act)
            ACT_CLEAR: begin
                count_next = '0;
                ovf_next   = 1'b0;
                perr_next  = 1'b0;
            end
            ACT_LOAD: begin
                count_next = BCD_i;
            end
            ACT_LOAD_BAD: begin
                count_next = LIMIT;
                perr_next  = 1'b1;
            end
            ACT_INC: begin
                // A carry out of the top digit means every digit was 9,
                // which can only be the terminal value; clamp rather than
                // silently wrapping if that invariant were ever broken.
                count_next = carry[DIGITS] ? LIMIT : inc_value;
            end
            ACT_WRAP: begin
                count_next = '0;
                ovf_next   = 1'b1;
            end
            ACT_SAT: begin
                ovf_next   = 1'b1;
            end
            default: begin
                count_next = count_reg;
            end
        endcase
    end

    // Counter and flag registers; reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            perr_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            perr_reg  <= perr_next;
        end
    end

    assign BCD_o = count_reg;
    assign ovf   = ovf_reg;
    assign perr  = perr_reg;

endmodule

// File: tb/tb_bcd_upcounter.sv
// Bench for bcd_upcounter: a wrapping and a saturating 00-59 counter share
// one stimulus stream and are checked every cycle against a decimal
// reference model; a 59/23 cascaded pair is checked as a 24h clock.
module tb_bcd_upcounter;

    localparam int LIM = 59;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       clr     = 1'b0;
    logic       preset  = 1'b0;
    logic       cin     = 1'b0;
    logic [7:0] bcd_in  = 8'h00;

    logic [7:0] q_w, q_s;
    logic       cout_w, cout_s, ovf_w, ovf_s, perr_w, perr_s;

    logic       rst_c_n = 1'b0;
    logic       cin_c   = 1'b0;
    logic       zero1   = 1'b0;
    logic [7:0] zero8   = 8'h00;
    logic [7:0] q_lo, q_hi;
    logic       cout_lo, cout_hi, ovf_lo, ovf_hi, perr_lo, perr_hi;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: index 0 = wrapping counter, 1 = saturating
    int m_cnt [2];
    bit m_ovf [2];
    bit m_perr[2];
    bit rst_seen = 1'b0;

    always #5 clk = ~clk;

    bcd_upcounter #(.DIGITS(2), .LIMIT(8'h59), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .preset(preset), .BCD_i(bcd_in),
        .cin(cin), .BCD_o(q_w), .cout(cout_w), .ovf(ovf_w), .perr(perr_w));

    bcd_upcounter #(.DIGITS(2), .LIMIT(8'h59), .WRAP(1'b0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .preset(preset), .BCD_i(bcd_in),
        .cin(cin), .BCD_o(q_s), .cout(cout_s), .ovf(ovf_s), .perr(perr_s));

    bcd_upcounter #(.DIGITS(2), .LIMIT(8'h59), .WRAP(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_c_n), .clr(zero1), .preset(zero1), .BCD_i(zero8),
        .cin(cin_c), .BCD_o(q_lo), .cout(cout_lo), .ovf(ovf_lo), .perr(perr_lo));

    bcd_upcounter #(.DIGITS(2), .LIMIT(8'h23), .WRAP(1'b1)) dut_hi (
        .clk(clk), .rst_n(rst_c_n), .clr(zero1), .preset(zero1), .BCD_i(zero8),
        .cin(cout_lo), .BCD_o(q_hi), .cout(cout_hi), .ovf(ovf_hi), .perr(perr_hi));

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rst_n) rst_seen = 1'b1;

    // Compare process: every cycle, check both counters against the model,
    // then advance the model with the inputs that the next edge will see.
    always begin
        @(negedge clk);
        #2;
        if (!rst_n || rst_seen) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i]  = 0;
                m_ovf[i]  = 1'b0;
                m_perr[i] = 1'b0;
            end
            if (rst_n) rst_seen = 1'b0;
        end
        chk8("q_wrap",    q_w,    int2bcd(m_cnt[0]));
        chk8("q_sat",     q_s,    int2bcd(m_cnt[1]));
        chk1("ovf_wrap",  ovf_w,  m_ovf[0]);
        chk1("ovf_sat",   ovf_s,  m_ovf[1]);
        chk1("perr_wrap", perr_w, m_perr[0]);
        chk1("perr_sat",  perr_s, m_perr[1]);
        chk1("cout_wrap", cout_w, cin && !clr && !preset && (m_cnt[0] == LIM));
        chk1("cout_sat",  cout_s, cin && !clr && !preset && (m_cnt[1] == LIM));
        chk1("range_wrap", (q_w[7:4] <= 4'd9) && (q_w[3:0] <= 4'd9) && (bcd2int(q_w) <= LIM), 1'b1);
        chk1("range_sat",  (q_s[7:4] <= 4'd9) && (q_s[3:0] <= 4'd9) && (bcd2int(q_s) <= LIM), 1'b1);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (clr) begin
                    m_cnt[i]  = 0;
                    m_ovf[i]  = 1'b0;
                    m_perr[i] = 1'b0;
                end else if (preset) begin
                    if (bcd_in[7:4] <= 4'd9 && bcd_in[3:0] <= 4'd9 && bcd2int(bcd_in) <= LIM) begin
                        m_cnt[i] = bcd2int(bcd_in);
                    end else begin
                        m_cnt[i]  = LIM;
                        m_perr[i] = 1'b1;
                    end
                end else if (cin) begin
                    if (m_cnt[i] == LIM) begin
                        m_ovf[i] = 1'b1;
                        if (i == 0) m_cnt[i] = 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
        end
    end

    // One clock of stimulus: drive on the falling edge, return after the
    // compare process has sampled so literal checks see the same values.
    task automatic drive(input logic c, input logic p, input logic ci, input logic [7:0] d);
        @(negedge clk);
        clr    = c;
        preset = p;
        cin    = ci;
        bcd_in = d;
        #3;
    endtask

    initial begin
        int         hits;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        #1;
        rst_n   = 1'b1;
        rst_c_n = 1'b1;

        // reset state
        drive(0, 0, 0, 8'h00);
        chk8("reset_q", q_w, 8'h00);
        chk1("reset_ovf", ovf_w, 1'b0);
        chk1("reset_perr", perr_w, 1'b0);
        chk1("reset_cout", cout_w, 1'b0);

        // 60 clocks of counting: cout only while showing 59, then wrap
        hits = 0;
        for (int k = 0; k < 60; k++) begin
            drive(0, 0, 1, 8'h00);
            if (k == 9) chk8("count_09", q_w, 8'h09);
            if (k == 10) chk8("count_10", q_w, 8'h10);
            if (cout_w === 1'b1) begin
                hits++;
                chk8("cout_at_59", q_w, 8'h59);
            end
        end
        chki("cout_pulses_60", hits, 1);
        drive(0, 0, 0, 8'h00);
        chk8("wrap_to_00", q_w, 8'h00);
        chk1("ovf_after_wrap", ovf_w, 1'b1);

        // saturating counter: 58 -> 59 -> 59 -> 59
        drive(1, 0, 0, 8'h00);
        drive(0, 1, 0, 8'h58);
        drive(0, 0, 1, 8'h00);
        chk8("sat_58", q_s, 8'h58);
        chk1("sat_cout_58", cout_s, 1'b0);
        drive(0, 0, 1, 8'h00);
        chk8("sat_59a", q_s, 8'h59);
        chk1("sat_cout_59a", cout_s, 1'b1);
        drive(0, 0, 1, 8'h00);
        chk8("sat_59b", q_s, 8'h59);
        chk1("sat_cout_59b", cout_s, 1'b1);
        chk1("sat_ovf", ovf_s, 1'b1);
        drive(0, 0, 0, 8'h00);
        chk8("sat_59c", q_s, 8'h59);

        // invalid presets load the limit and set perr; clr wipes everything
        drive(0, 1, 0, 8'h3A);
        drive(0, 1, 0, 8'h72);
        chk8("bad_3a_q", q_w, 8'h59);
        chk1("bad_3a_perr", perr_w, 1'b1);
        drive(1, 0, 0, 8'h00);
        chk8("bad_72_q", q_w, 8'h59);
        chk1("bad_72_perr", perr_w, 1'b1);
        drive(0, 0, 0, 8'h00);
        chk8("clr_q", q_w, 8'h00);
        chk1("clr_perr", perr_w, 1'b0);
        chk1("clr_ovf", ovf_w, 1'b0);

        // priority: load beats count, clear beats load
        drive(0, 1, 1, 8'h27);
        chk1("prio_load_cout", cout_w, 1'b0);
        drive(1, 1, 1, 8'hFF);
        chk8("prio_load_q", q_w, 8'h27);
        chk1("prio_clr_cout", cout_w, 1'b0);
        drive(0, 0, 0, 8'h00);
        chk8("prio_clr_q", q_w, 8'h00);
        chk1("prio_clr_perr", perr_w, 1'b0);

        // randomized traffic, checked by the compare process
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 1) == 0) d = int2bcd(int'($urandom_range(0, 99)));
            else d = 8'($urandom);
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, d);
        end

        // asynchronous reset in the middle of a count
        drive(0, 1, 0, 8'hFF);
        drive(0, 1, 0, 8'h59);
        drive(0, 0, 1, 8'h00);
        drive(0, 1, 0, 8'h30);
        repeat (7) drive(0, 0, 1, 8'h00);
        drive(0, 0, 0, 8'h00);
        chk8("pre_rst_q", q_w, 8'h37);
        chk1("pre_rst_ovf", ovf_w, 1'b1);
        chk1("pre_rst_perr", perr_w, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk8("async_rst_q", q_w, 8'h00);
        chk1("async_rst_ovf", ovf_w, 1'b0);
        chk1("async_rst_perr", perr_w, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 8'h00);
        chk8("post_rst_q", q_w, 8'h00);

        // cascaded 59/23 pair counts a full day of seconds-as-minutes
        hits = 0;
        for (int k = 0; k < 1440; k++) begin
            @(negedge clk);
            cin_c = 1'b1;
            #3;
            chk8("casc_lo", q_lo, int2bcd(k % 60));
            chk8("casc_hi", q_hi, int2bcd((k / 60) % 24));
            chk1("casc_lo_cout", cout_lo, (k % 60) == 59);
            chk1("casc_hi_cout", cout_hi, k == 1439);
            if (k == 1439) begin
                chk8("casc_2359_hi", q_hi, 8'h23);
                chk8("casc_2359_lo", q_lo, 8'h59);
            end
            if (cout_hi === 1'b1) hits++;
        end
        @(negedge clk);
        cin_c = 1'b0;
        #3;
        chk8("casc_wrap_hi", q_hi, 8'h00);
        chk8("casc_wrap_lo", q_lo, 8'h00);
        chk1("casc_hi_ovf", ovf_hi, 1'b1);
        chki("casc_hi_pulses", hits, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
